// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Produces the pixel position, sync levels, visible-area flag, line/frame
// strobes and a completed-frame counter for a parameterised raster (640x480@60
// by default). Every output is driven straight from a flop, so the sync lines
// cannot glitch. Sync levels and display_on are computed from the *next*
// counter values, which keeps them aligned with hpos/vpos in the same cycle.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  // Raster geometry, all in 10-bit counter space.
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Idle (inactive) sync level.
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [9:0] hpos_reg;
  logic [9:0] vpos_reg;
  logic [9:0] hpos_next;
  logic [9:0] vpos_next;
  logic       h_wrap;
  logic       v_wrap;

  logic       hsync_reg;
  logic       vsync_reg;
  logic       display_on_reg;
  logic       hsync_next;
  logic       vsync_next;
  logic       display_on_next;

  logic       line_start_reg;
  logic       frame_start_reg;
  logic       line_start_next;
  logic       frame_start_next;

  logic [7:0] frame_cnt_reg;
  logic [7:0] frame_cnt_next;

  // Next raster position: horizontal steps every pixel, vertical only on the
  // horizontal wrap; both wrap together at the last pixel of the last line.
  always_comb begin
    h_wrap    = (hpos_reg == H_LAST);
    v_wrap    = (vpos_reg == V_LAST);
    hpos_next = h_wrap ? 10'd0 : (hpos_reg + 10'd1);
    vpos_next = vpos_reg;
    if (h_wrap) begin
      vpos_next = v_wrap ? 10'd0 : (vpos_reg + 10'd1);
    end
  end

  // Levels derived from the next position, so they land in the same cycle as
  // the position they describe.
  always_comb begin
    hsync_next = SYNC_IDLE;
    vsync_next = SYNC_IDLE;
    if ((hpos_next >= H_SYNC_FIRST) && (hpos_next <= H_SYNC_LAST)) begin
      hsync_next = SYNC_POL;
    end
    if ((vpos_next >= V_SYNC_FIRST) && (vpos_next <= V_SYNC_LAST)) begin
      vsync_next = SYNC_POL;
    end
    display_on_next = (hpos_next < H_VISIBLE) && (vpos_next < V_VISIBLE);
  end

  // Strobes mark the cycle right after an advance lands on column 0 / (0,0);
  // the frame counter counts those same (0,0) landings.
  always_comb begin
    line_start_next  = en && h_wrap;
    frame_start_next = en && h_wrap && v_wrap;
    frame_cnt_next   = frame_cnt_reg;
    if (frame_start_next) begin
      frame_cnt_next = frame_cnt_reg + 8'd1;
    end
  end

  // Position counters advance only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_reg <= 10'd0;
      vpos_reg <= 10'd0;
    end else if (en) begin
      hpos_reg <= hpos_next;
      vpos_reg <= vpos_next;
    end
  end

  // Sync and visible-area levels; reset values describe position (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_reg      <= SYNC_IDLE;
      vsync_reg      <= SYNC_IDLE;
      display_on_reg <= 1'b1;
    end else if (en) begin
      hsync_reg      <= hsync_next;
      vsync_reg      <= vsync_next;
      display_on_reg <= display_on_next;
    end
  end

  // One-cycle strobes; forced low on any cycle without an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  // Completed-frame counter, wraps naturally modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= 8'd0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign hpos        = hpos_reg;
  assign vpos        = vpos_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign display_on  = display_on_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus two small-raster
// instances (active-low and active-high sync). A reference model derives every
// output from the number of enabled advances since reset using division and
// modulo, and is compared against all three instances every cycle. Directed
// literal checks pin the model at hand-computed points.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  // Small raster: 15 pixels x 11 lines = 165 cycles per frame.
  localparam int SHD = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVD = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int S_FRAME = (SHD + SHF + SHS + SHB) * (SVD + SVF + SVS + SVB);

  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos, p_hpos, p_vpos;
  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic p_hs, p_vs, p_de, p_ls, p_fs;
  logic [7:0] d_fc, s_fc, p_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hs), .vsync(d_vs),
    .display_on(d_de), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hs), .vsync(s_vs),
    .display_on(s_de), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hpos(p_hpos), .vpos(p_vpos), .hsync(p_hs), .vsync(p_vs),
    .display_on(p_de), .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model state: advances since reset, and whether the last edge advanced.
  int n_adv;
  bit adv_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_adv    <= 0;
      adv_last <= 1'b0;
    end else begin
      adv_last <= en;
      if (en) n_adv <= n_adv + 1;
    end
  end

  // Expected {hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt}.
  function automatic logic [32:0] expect_vec(input int n, input bit adv,
      input int hd, input int hf, input int hsw, input int hb,
      input int vd, input int vf, input int vsw, input int vb, input bit pol);
    int ht, vt, hp, vp, fc;
    logic hs, vs, de, ls, fs;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    hp = n % ht;
    vp = (n / ht) % vt;
    fc = (n / (ht * vt)) % 256;
    hs = (hp >= hd + hf && hp < hd + hf + hsw) ? pol : !pol;
    vs = (vp >= vd + vf && vp < vd + vf + vsw) ? pol : !pol;
    de = (hp < hd) && (vp < vd);
    ls = adv && (hp == 0);
    fs = adv && (hp == 0) && (vp == 0);
    return {hp[9:0], vp[9:0], hs, vs, de, ls, fs, fc[7:0]};
  endfunction

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [32:0] e, a;
      e = expect_vec(n_adv, adv_last, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      a = {d_hpos, d_vpos, d_hs, d_vs, d_de, d_ls, d_fs, d_fc};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_def n=%0d got=%h want=%h", n_adv, a, e);
      end
      e = expect_vec(n_adv, adv_last, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 1'b0);
      a = {s_hpos, s_vpos, s_hs, s_vs, s_de, s_ls, s_fs, s_fc};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_small n=%0d got=%h want=%h", n_adv, a, e);
      end
      e = expect_vec(n_adv, adv_last, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 1'b1);
      a = {p_hpos, p_vpos, p_hs, p_vs, p_de, p_ls, p_fs, p_fc};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_pol n=%0d got=%h want=%h", n_adv, a, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end else begin
      $display("[TB] check %s = %0d ok", name, act);
    end
  endtask

  task automatic step(input int k);
    en = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  task automatic idle(input int k);
    en = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int rem;
    rst_n = 1'b1;
    en    = 1'b0;
    #2 rst_n = 1'b0;
    #5 chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("rst_hpos", d_hpos, 0);
    chk("rst_vpos", d_vpos, 0);
    chk("rst_hsync_def", d_hs, 1);
    chk("rst_vsync_def", d_vs, 1);
    chk("rst_hsync_pol", p_hs, 0);
    chk("rst_display_on", d_de, 1);
    chk("rst_strobes", {d_ls, d_fs}, 0);
    chk("rst_frame_cnt", d_fc, 0);

    // First line of the default raster.
    rst_n = 1'b1;
    step(640);
    chk("h640_hpos", d_hpos, 640);
    chk("h640_display_on", d_de, 0);
    chk("h640_hsync", d_hs, 1);
    step(16);
    chk("h656_hsync", d_hs, 0);
    chk("pol_hpos_at656", p_hpos, 11);
    chk("pol_hsync_at656", p_hs, 1);
    step(96);
    chk("h752_hpos", d_hpos, 752);
    chk("h752_hsync", d_hs, 1);
    step(48);
    chk("line1_hpos", d_hpos, 0);
    chk("line1_vpos", d_vpos, 1);
    chk("line1_line_start", d_ls, 1);
    chk("line1_frame_start", d_fs, 0);

    // Random enable pattern.
    for (int i = 0; i < 40000; i++) begin
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    // Drive the small raster to the last pixel of frame 255, then wrap.
    rem = 256 * S_FRAME - n_adv;
    chk("wrap_reachable", (rem > 1) ? 1 : 0, 1);
    if (rem > 1) begin
      step(rem - 1);
      chk("pre_wrap_hpos", s_hpos, 14);
      chk("pre_wrap_vpos", s_vpos, 10);
      chk("pre_wrap_frame_cnt", s_fc, 255);
      step(1);
      chk("wrap_pos", {s_hpos, s_vpos}, 0);
      chk("wrap_frame_start", s_fs, 1);
      chk("wrap_line_start", s_ls, 1);
      chk("wrap_frame_cnt", s_fc, 0);
    end

    // Enable toggling around the end of a line.
    step(14);
    chk("tog_hpos", s_hpos, 14);
    idle(3);
    chk("frz_hpos", s_hpos, 14);
    chk("frz_line_start", s_ls, 0);
    step(1);
    chk("adv_hpos", s_hpos, 0);
    chk("adv_line_start", s_ls, 1);
    step(1);
    chk("post_line_start", s_ls, 0);

    // Asynchronous reset between clock edges.
    step(5);
    @(posedge clk);
    #1 chk("pre_rst_hpos", s_hpos, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_hpos", s_hpos, 0);
    chk("arst_vpos", s_vpos, 0);
    chk("arst_def_hpos", d_hpos, 0);
    chk("arst_hsync", d_hs, 1);
    chk("arst_display_on", s_de, 1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rel_hpos", s_hpos, 1);
    chk("rel_strobes", {s_ls, s_fs, d_ls, d_fs}, 0);
    step(20);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parameterised VGA raster timing generator for 640x480@60 Hz, clocked at the 25.175 MHz pixel clock. It drives the pixel position, sync and blanking signals consumed by the pattern/colour logic in the top-level wrapper. The pattern logic maps `hpos`/`vpos`/`display_on` to 2-bit RGB, and the wrapper packs `hsync`/`vsync` onto the TinyVGA PMOD pins. All outputs come directly from flops, so sync lines are glitch-free.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, level of `hsync`/`vsync` while active (0 = active-low)
- `clk` input 1: pixel clock; the only clock
- `rst_n` input 1: reset, asynchronous, active-low
- `en` input 1: pixel advance enable; counters step only when 1
- `hpos` output 10: current column, 0..H_TOTAL-1
- `vpos` output 10: current line, 0..V_TOTAL-1
- `hsync` output 1: horizontal sync, level per `SYNC_POL`
- `vsync` output 1: vertical sync, level per `SYNC_POL`
- `display_on` output 1: current position lies in the visible area
- `line_start` output 1: one-cycle strobe when `hpos` becomes 0
- `frame_start` output 1: one-cycle strobe when (`hpos`,`vpos`) becomes (0,0)
- `frame_cnt` output 8: completed-frame counter, wraps modulo 256

## Operation
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
- Horizontal counter, on each `en`=1 cycle: increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the horizontal wrap; at V_TOTAL-1 it wraps to 0 on that same horizontal wrap.
- The horizontal counter is the line state: visible [0,639], front porch [640,655], sync [656,751], back porch [752,799].
- `hsync` is active iff `hpos` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; otherwise it holds `~SYNC_POL`.
- `vsync` is active iff `vpos` is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. lines 490..491 by default.
- `display_on` = (`hpos` < H_DISPLAY) && (`vpos` < V_DISPLAY).
- `hsync`, `vsync` and `display_on` are registered from next-state counter values. They therefore always describe the `hpos`/`vpos` present in the same cycle, with zero skew.
- `en`=0: all counters and levels hold; strobes are 0.
- `line_start`: 1 for exactly the cycle after an `en` advance lands on `hpos`=0.
- `frame_start`: same rule, for the landing on (0,0).
- `frame_cnt`: +1 on each landing on (0,0); 255 wraps to 0.
- Counter arithmetic is 10-bit unsigned; all defaults fit.

## Timing
- Reset (`rst_n`=0, takes effect immediately, no clock needed):
  - `hpos`=0, `vpos`=0, `frame_cnt`=0.
  - `hsync`=`vsync`=`~SYNC_POL`.
  - `display_on`=1.
  - `line_start`=`frame_start`=0.
- Reset asserted mid-frame: everything returns to the reset values asynchronously. No strobe is produced on release.
- After release: the first `en`=1 rising edge moves `hpos` 0→1. Position (0,0) is entered again only by wrap.
- Latency: 0 cycles between `hpos`/`vpos` and `hsync`/`vsync`/`display_on`.
- With `en` tied to 1, periods are:
  - `hsync`: 800 cycles, active 96.
  - `vsync`: 420000 cycles, active 1600.
  - `frame_start`: every 420000 cycles.
- Simultaneous horizontal and vertical wrap at (799,524): the next cycle shows (0,0) with `line_start`=`frame_start`=1 and `frame_cnt` incremented.

## Test plan
- Reset, then `en`=1 for 800 cycles:
  - `hsync` goes active at `hpos`=656 and inactive at 752.
  - `display_on` falls at `hpos`=640.
  - `line_start`=1 at the cycle `hpos`=0, `vpos`=1.
- Full frame with `en`=1:
  - `vsync` is active exactly for `vpos` 490..491 (1600 cycles).
  - `display_on` is never 1 when `vpos` ≥ 480.
  - `frame_start` fires after 420000 cycles with `frame_cnt`=1.
- `en` toggling 1-0-1 around `hpos`=799:
  - Counters and levels freeze while `en`=0.
  - A single `line_start` pulse appears only after the advancing cycle.
- Run 256 frames (or force the counters to (799,524) with `frame_cnt`=255): `frame_cnt` wraps to 0 together with a `frame_start` pulse.
- Assert `rst_n`=0 asynchronously at (700,300) between clock edges:
  - Outputs reach the reset values before the next edge.
  - After release, no strobe is produced and `hpos` resumes 0→1.
- `SYNC_POL`=1 build: sync pulses are high, idle low, at the same positions as the default build.
